// File: rtl/cdf_pkg.sv
// Shared definitions for the CDF pipeline: table geometry, word tag and the tagged-word format
// used by both the write-back (store) and fetch stages.
package cdf_pkg;

    localparam int          NUM_BINS = 256;
    localparam int          DATA_W   = 20;
    localparam int          WORD_W   = 128;
    localparam logic [15:0] TAG      = 16'hAAAA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Tagged word: [127:36]=0, [35:20]=tag, [19:0]=value
    function automatic logic [WORD_W-1:0] pack_word(input logic [15:0]       tag,
                                                    input logic [DATA_W-1:0] val);
        return {{(WORD_W-16-DATA_W){1'b0}}, tag, val};
    endfunction

endpackage

// File: rtl/cdf_store.sv
// CDF write-back stage: packs one CDF value per cycle into a tagged word, writes one word per bin
// into the selected table half, and tracks frame completion, first non-zero value and monotonicity.
module cdf_store
    import cdf_pkg::*;
#(
    parameter int          NUM_BINS = cdf_pkg::NUM_BINS,
    parameter int          DATA_W   = cdf_pkg::DATA_W,
    parameter int          ADDR_W   = 16,
    parameter logic [15:0] TAG      = cdf_pkg::TAG
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              StartIn,
    input  logic [DATA_W-1:0] CdfIn,
    input  logic              output_base_offset,
    output logic              WriteEnable,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [127:0]      WriteBus,
    output logic              Done,
    output logic [DATA_W-1:0] CdfMin,
    output logic              MonoErr
);

    localparam int CNT_W = $clog2(NUM_BINS) + 1;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_base;
    logic [DATA_W-1:0] r_prev;

    logic              w_base;
    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;

    // The first sample of a frame uses the live offset; later samples use the latched copy.
    assign w_base   = (r_state == IDLE) ? output_base_offset : r_base;
    assign w_accept = StartIn && ((r_state == IDLE) || (r_state == WRITE));
    assign w_last   = (r_cnt == CNT_W'(NUM_BINS - 1));
    assign w_addr   = ({{(ADDR_W-1){1'b0}}, w_base} << (ADDR_W - 1)) | ADDR_W'(r_cnt);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_base       <= 1'b0;
            r_prev       <= '0;
            WriteEnable  <= 1'b0;
            WriteAddress <= '0;
            WriteBus     <= '0;
            Done         <= 1'b0;
            CdfMin       <= '0;
            MonoErr      <= 1'b0;
        end else begin
            WriteEnable <= 1'b0;
            if (w_accept) begin
                WriteEnable  <= 1'b1;
                WriteAddress <= w_addr;
                WriteBus     <= pack_word(TAG, CdfIn);
                r_prev       <= CdfIn;
            end

            case (r_state)
                IDLE: begin
                    Done  <= 1'b0;
                    r_cnt <= '0;
                    if (StartIn) begin
                        r_base  <= output_base_offset;
                        MonoErr <= 1'b0;
                        CdfMin  <= CdfIn;
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (!StartIn) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        if (CdfIn < r_prev) MonoErr <= 1'b1;
                        if (CdfMin == '0)   CdfMin  <= CdfIn;
                        if (w_last) begin
                            r_state <= DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Samples arriving here are dropped; Done drops one edge after leaving.
                    Done <= 1'b1;
                    if (!StartIn) r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdf_store.sv
// Directed bench for cdf_store: full frames on both halves, abort, overrun, monotonicity, mid-frame reset.
module tb_cdf_store;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         StartIn = 1'b0;
    logic [19:0]  CdfIn = '0;
    logic         output_base_offset = 1'b0;
    logic         WriteEnable;
    logic [15:0]  WriteAddress;
    logic [127:0] WriteBus;
    logic         Done;
    logic [19:0]  CdfMin;
    logic         MonoErr;

    cdf_store dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .StartIn            (StartIn),
        .CdfIn              (CdfIn),
        .output_base_offset (output_base_offset),
        .WriteEnable        (WriteEnable),
        .WriteAddress       (WriteAddress),
        .WriteBus           (WriteBus),
        .Done               (Done),
        .CdfMin             (CdfMin),
        .MonoErr            (MonoErr)
    );

    always #5 clock = ~clock;

    int           n_chk  = 0;
    int           n_pass = 0;
    logic [19:0]  stim  [0:299];
    logic         bstim [0:299];
    logic [15:0]  mon_addr [0:511];
    logic [127:0] mon_data [0:511];
    int           mon_n = 0;
    logic         done_seen = 1'b0;

    // Write log, sampled mid-cycle
    always @(negedge clock) begin
        if (WriteEnable && mon_n < 512) begin
            mon_addr[mon_n] = WriteAddress;
            mon_data[mon_n] = WriteBus;
            mon_n = mon_n + 1;
        end
        if (Done) done_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic drive(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            StartIn = 1'b1;
            CdfIn = stim[i];
            output_base_offset = bstim[i];
            @(posedge clock); #1;
        end
    endtask

    task automatic idle(input int n);
        StartIn = 1'b0;
        CdfIn = '0;
        output_base_offset = 1'b0;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic clr_log();
        mon_n = 0;
        done_seen = 1'b0;
    endtask

    // Compare the logged words against the stimulus table and the expected table half
    task automatic verify(input string tag, input int n, input logic hi);
        int bad;
        logic [15:0]  ea;
        logic [127:0] ed;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            ea = {hi, 15'b0} | 16'(i);
            ed = {92'b0, 16'hAAAA, stim[i]};
            if (mon_addr[i] !== ea || mon_data[i] !== ed) begin
                if (bad == 0) $display("FAIL %s_word%0d: got %0h/%0h want %0h/%0h",
                                       tag, i, mon_addr[i], mon_data[i], ea, ed);
                bad++;
            end
        end
        chk({tag, "_badwords"}, 128'(bad), 128'd0);
    endtask

    initial begin
        for (int i = 0; i < 300; i++) begin
            stim[i]  = 20'(i + 1);
            bstim[i] = 1'b0;
        end

        // Reset state
        #2 reset_n = 1'b0;
        @(posedge clock); #1;
        chk("rst_we",   128'(WriteEnable),  128'd0);
        chk("rst_addr", 128'(WriteAddress), 128'd0);
        chk("rst_bus",  WriteBus,           128'd0);
        chk("rst_done", 128'(Done),         128'd0);
        chk("rst_min",  128'(CdfMin),       128'd0);
        chk("rst_mono", 128'(MonoErr),      128'd0);
        reset_n = 1'b1;
        idle(2);

        // Full frame, base 0, CdfIn = i+1
        clr_log();
        drive(0, 256);
        StartIn = 1'b0;
        @(posedge clock); #1;
        chk("f0_done_rise", 128'(Done),        128'd1);
        chk("f0_we_off",    128'(WriteEnable), 128'd0);
        chk("f0_bus_hold",  WriteBus,          {92'b0, 16'hAAAA, 20'd256});
        chk("f0_addr_hold", 128'(WriteAddress), 128'h00FF);
        @(posedge clock); #1;
        chk("f0_done_fall", 128'(Done),    128'd0);
        chk("f0_count",     128'(mon_n),   128'd256);
        chk("f0_min",       128'(CdfMin),  128'd1);
        chk("f0_mono",      128'(MonoErr), 128'd0);
        verify("f0", 256, 1'b0);
        idle(2);

        // Base 1, ten leading zeros then 5,5,6,7..., offset toggling mid-frame
        for (int i = 0; i < 256; i++) begin
            stim[i]  = (i < 10) ? 20'd0 : (i == 10) ? 20'd5 : 20'(i - 6);
            bstim[i] = (i == 0) ? 1'b1 : ((i % 3) == 0);
        end
        clr_log();
        drive(0, 256);
        idle(1);
        chk("f1_done",  128'(Done),    128'd1);
        chk("f1_count", 128'(mon_n),   128'd256);
        chk("f1_min",   128'(CdfMin),  128'd5);
        chk("f1_mono",  128'(MonoErr), 128'd0);
        verify("f1", 256, 1'b1);
        idle(2);
        for (int i = 0; i < 300; i++) begin
            stim[i]  = 20'(i + 1);
            bstim[i] = 1'b0;
        end

        // Abort after 100 samples
        clr_log();
        drive(0, 100);
        idle(4);
        chk("ab_count", 128'(mon_n),     128'd100);
        chk("ab_done",  128'(done_seen), 128'd0);
        verify("ab", 100, 1'b0);

        // Overrun: 300 samples, only 256 written, restart from index 0
        clr_log();
        drive(0, 300);
        chk("ov_done_held", 128'(Done), 128'd1);
        StartIn = 1'b0;
        @(posedge clock); #1;
        chk("ov_done_stay", 128'(Done), 128'd1);
        @(posedge clock); #1;
        chk("ov_done_clr",  128'(Done),  128'd0);
        chk("ov_count",     128'(mon_n), 128'd256);
        verify("ov", 256, 1'b0);
        idle(2);

        // Monotonicity: 10,20,15,30,...
        stim[0] = 20'd10; stim[1] = 20'd20; stim[2] = 20'd15;
        for (int i = 3; i < 256; i++) stim[i] = 20'(27 + i);
        clr_log();
        drive(0, 2);
        chk("mo_before", 128'(MonoErr), 128'd0);
        drive(2, 3);
        chk("mo_set",    128'(MonoErr), 128'd1);
        drive(3, 256);
        idle(1);
        chk("mo_sticky", 128'(MonoErr), 128'd1);
        chk("mo_count",  128'(mon_n),   128'd256);
        chk("mo_min",    128'(CdfMin),  128'd10);
        verify("mo", 256, 1'b0);
        idle(2);
        stim[0] = 20'd1;
        drive(0, 1);
        chk("mo_clear",  128'(MonoErr), 128'd0);
        chk("mo_newmin", 128'(CdfMin),  128'd1);
        idle(2);

        // Reset mid-frame at bin 50
        for (int i = 0; i < 300; i++) stim[i] = 20'(i + 3);
        clr_log();
        drive(0, 50);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_we",   128'(WriteEnable),  128'd0);
        chk("mr_addr", 128'(WriteAddress), 128'd0);
        chk("mr_bus",  WriteBus,           128'd0);
        chk("mr_done", 128'(Done),         128'd0);
        chk("mr_min",  128'(CdfMin),       128'd0);
        StartIn = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(1);
        clr_log();
        drive(0, 256);
        idle(1);
        chk("mr_count", 128'(mon_n),  128'd256);
        chk("mr_fdone", 128'(Done),   128'd1);
        chk("mr_fmin",  128'(CdfMin), 128'd3);
        verify("mr", 256, 1'b0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cdf_store.md
# cdf_store

Write-back stage of the CDF pipeline: the writer counterpart to the fetch stage's tagged-word reader. Takes one accumulated CDF value per cycle from the accumulate stage and packs it into a 128-bit tagged memory word. Writes one word per bin into a 256-entry table, selectable between two memory halves. Tracks frame completion, the first non-zero CDF value (cdf_min, needed by the equalisation stage) and monotonicity violations.

## Interface
- NUM_BINS, 256, bins per frame (power of two, ≤ 2^15)
- DATA_W, 20, CDF value width
- ADDR_W, 16, memory address width
- TAG, 16'hAAAA, valid-word tag written to bits [35:20]

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  reset; asynchronous, active-low
- StartIn  in  1  frame-active / data-valid from accumulate stage
- CdfIn  in  DATA_W  CDF value, valid when StartIn=1
- output_base_offset  in  1  selects table half; sampled at frame start
- WriteEnable  out  1  memory write strobe
- WriteAddress  out  ADDR_W  memory write address
- WriteBus  out  128  memory write data
- Done  out  1  frame of NUM_BINS words completely written
- CdfMin  out  DATA_W  first non-zero CdfIn of the last frame
- MonoErr  out  1  sticky: CdfIn decreased within the current frame

## Operation
- Word format: [127:36]=0, [35:20]=TAG, [19:0]=CdfIn.
- Address = {base, 15'b0} | index, index = 0..NUM_BINS-1. base is output_base_offset latched on the first sample of the frame and held for the whole frame.
- FSM states:
  - IDLE: outputs quiet. StartIn=1 → write index 0, latch base, clear MonoErr and CdfMin, go to WRITE.
  - WRITE: each cycle with StartIn=1, write the next index. After the write of index NUM_BINS-1, go to DONE. StartIn=0 before NUM_BINS samples → abort: go to IDLE, count cleared, Done stays 0, CdfMin/MonoErr keep their partial values.
  - DONE: Done=1, no writes. Further StartIn=1 samples are dropped. StartIn=0 → IDLE, Done cleared.
- CdfMin: loaded with the first sample whose CdfIn≠0; later samples do not change it. If every sample is 0, it stays 0.
- MonoErr: set when CdfIn < the previous sample of the same frame. It is sticky until the next frame start and does not stop writes.
- Bin counter is 9 bits for NUM_BINS=256. No wrap: the index never exceeds NUM_BINS-1.
- Reset values: WriteEnable=0, WriteAddress=0, WriteBus=0, Done=0, CdfMin=0, MonoErr=0, state IDLE, count 0, base 0.

## Timing
- All outputs are registered.
- A sample taken at edge k appears as WriteEnable=1 with its address and data after edge k, i.e. 1-cycle latency.
- WriteEnable is 1 for exactly one cycle per accepted sample. WriteBus and WriteAddress hold their last values when WriteEnable=0.
- Done rises on the edge after the final write; it is high the cycle after the last WriteEnable pulse.
- Done falls on the edge after StartIn is sampled low.
- If StartIn drops at the same edge the NUM_BINS-th sample would have been taken, the frame is treated as aborted.
- MonoErr and CdfMin update on the same edge as the corresponding write.
- Reset asserted mid-frame clears everything immediately, with no partial Done.
- The first StartIn=1 after reset starts a fresh frame.

## Structure
- Shared package cdf_pkg holds:
  - the TAG, NUM_BINS and DATA_W constants;
  - the state enum {IDLE, WRITE, DONE};
  - a word-packing function, shared with the fetch stage so both ends agree on the format.
- Single module, no sub-module: the FSM, counter and packing are small enough to live in one block.

## Test plan
- Full frame, base 0: StartIn=1 for 256 cycles, CdfIn=i+1 → 256 WriteEnable pulses at addresses 0x0000..0x00FF, data {92'b0,16'hAAAA,CdfIn}. Done=1 the cycle after the last pulse. CdfMin=1, MonoErr=0.
- Base 1, leading zeros: output_base_offset=1, CdfIn=0 for bins 0..9, then 5,5,6,... → addresses 0x8000..0x80FF, CdfMin=5. Toggling output_base_offset mid-frame does not change the address high bit.
- Abort: StartIn drops after 100 samples → 100 writes, Done stays 0. The next frame restarts at index 0.
- Overrun: StartIn held for 300 cycles → exactly 256 writes. Done stays high until StartIn=0, then clears one cycle later.
- Monotonicity: CdfIn sequence 10,20,15,30 within a frame → MonoErr=1 from the write of 15 onward. All 256 writes still occur. MonoErr clears at the next frame start.
- Reset mid-frame: reset_n pulsed low at bin 50 → all outputs 0 asynchronously. After release, a new frame writes from index 0.
